// File: rtl/tiled_matrix_multiplier_pkg.sv
// tiled_matrix_multiplier_pkg: default geometry, FSM encoding and result-width helper
package tiled_matrix_multiplier_pkg;
  localparam int N_DEF = 4;
  localparam int M_DEF = 2;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_e;
  function automatic int aw_f(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction
endpackage

// File: rtl/tiled_matrix_multiplier_mac_lane.sv
// tiled_matrix_multiplier_mac_lane: one signed MAC lane; presents the finished dot product
// (optionally added to the old Z) while the last k is being processed
module tiled_matrix_multiplier_mac_lane #(
  parameter int DW = 16,
  parameter int AW = 34
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          last_i,
  input  logic          acc_mode_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [AW-1:0] z_old_i,
  output logic [AW-1:0] z_new_o
);
  localparam int PW = 2 * DW;
  logic signed [PW-1:0] a_x, b_x, prod;
  logic signed [AW-1:0] acc_q, acc_d;
  assign a_x = PW'($signed(a_i));
  assign b_x = PW'($signed(b_i));
  assign prod = a_x * b_x;
  assign acc_d = acc_q + AW'(prod);
  assign z_new_o = acc_d + (acc_mode_i ? z_old_i : '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else if (en_i) acc_q <= last_i ? '0 : acc_d;
  end
endmodule

// File: rtl/tiled_matrix_multiplier.sv
// tiled_matrix_multiplier: Z = A*B (or Z += A*B) over NxN signed matrices with M MAC lanes,
// on-chip A/B load port, busy/done/ld_err handshake and a registered Z read port
module tiled_matrix_multiplier
  import tiled_matrix_multiplier_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int DW = DW_DEF,
  localparam int IW = $clog2(N),
  localparam int AW = aw_f(DW, N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic          ld_sel,
  input  logic [IW-1:0] ld_i,
  input  logic [IW-1:0] ld_j,
  input  logic [DW-1:0] ld_data,
  output logic          ld_err,
  input  logic          start,
  input  logic          acc_mode,
  output logic          busy,
  output logic          done,
  input  logic [IW-1:0] z_i,
  input  logic [IW-1:0] z_j,
  output logic [AW-1:0] z_out
);
  localparam int GW = (N / M > 1) ? $clog2(N / M) : 1;
  state_e        state_q;
  logic          busy_q, done_q, ld_err_q, acc_mode_q;
  logic [IW-1:0] i_q, k_q;
  logic [GW-1:0] g_q;
  logic [AW-1:0] z_out_q;
  logic [DW-1:0] a_q [N][N];
  logic [DW-1:0] b_q [N][N];
  logic [AW-1:0] z_q [N][N];
  logic [IW-1:0] col [M];
  logic [AW-1:0] z_new [M];
  logic          k_last, g_last, i_last, en;
  assign k_last = k_q == IW'(N - 1);
  assign g_last = g_q == GW'(N / M - 1);
  assign i_last = i_q == IW'(N - 1);
  assign en = state_q == COMPUTE;
  for (genvar l = 0; l < M; l++) begin : g_lane
    assign col[l] = IW'(l) + IW'(M) * IW'(g_q);
    tiled_matrix_multiplier_mac_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .last_i     (k_last),
      .acc_mode_i (acc_mode_q),
      .a_i        (a_q[i_q][k_q]),
      .b_i        (b_q[k_q][col[l]]),
      .z_old_i    (z_q[i_q][col[l]]),
      .z_new_o    (z_new[l])
    );
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ld_err_q <= 1'b0;
      acc_mode_q <= 1'b0;
      i_q <= '0;
      g_q <= '0;
      k_q <= '0;
      z_out_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      z_q <= '{default: '0};
    end else begin
      ld_err_q <= ld_valid && state_q != IDLE;
      z_out_q <= z_q[z_i][z_j];
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_valid && ld_sel) b_q[ld_i][ld_j] <= ld_data;
          if (ld_valid && !ld_sel) a_q[ld_i][ld_j] <= ld_data;
          if (start) begin
            state_q <= COMPUTE;
            busy_q <= 1'b1;
            acc_mode_q <= acc_mode;
          end
        end
        COMPUTE: begin
          k_q <= k_q + 1'b1;
          if (k_last) begin
            for (int l = 0; l < M; l++) z_q[i_q][col[l]] <= z_new[l];
            g_q <= g_last ? '0 : g_q + 1'b1;
            if (g_last) i_q <= i_q + 1'b1;
            if (g_last && i_last) begin
              state_q <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign ld_err = ld_err_q;
  assign z_out = z_out_q;
endmodule

// File: tb/tb_tiled_matrix_multiplier.sv
// tb_tiled_matrix_multiplier: directed scoreboard bench; an M=2 and an M=4 instance share
// all inputs so both must produce identical Z while their busy lengths differ
module tb_tiled_matrix_multiplier;
  localparam int IW = 2;
  localparam int AW = 34;
  typedef struct {
    int r;
    int c;
    logic [AW-1:0] e;
  } rd_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ld_valid = 1'b0, ld_sel = 1'b0, start = 1'b0, acc_mode = 1'b0;
  logic [IW-1:0] ld_i = '0, ld_j = '0, z_i = '0, z_j = '0;
  logic [15:0] ld_data = '0;
  logic ld_err, busy, done, ld_err4, busy4, done4;
  logic [AW-1:0] z_out, z_out4;
  logic rd_req = 1'b0, rd_fire = 1'b0;
  rd_t exp_q[$];
  int n_vec = 0, n_miss = 0;
  int busy_n = 0, busy4_n = 0, done_n = 0, done4_n = 0, err_n = 0, err4_n = 0;

  tiled_matrix_multiplier #(.N(4), .M(2), .DW(16)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_i(ld_i), .ld_j(ld_j),
    .ld_data(ld_data), .ld_err(ld_err), .start(start), .acc_mode(acc_mode), .busy(busy),
    .done(done), .z_i(z_i), .z_j(z_j), .z_out(z_out));
  tiled_matrix_multiplier #(.N(4), .M(4), .DW(16)) dut4 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_i(ld_i), .ld_j(ld_j),
    .ld_data(ld_data), .ld_err(ld_err4), .start(start), .acc_mode(acc_mode), .busy(busy4),
    .done(done4), .z_i(z_i), .z_j(z_j), .z_out(z_out4));

  always #5 clk = ~clk;
  always @(posedge clk) rd_fire <= rd_req;

  // monitor: event counters plus scoreboard pop for every registered read
  always @(negedge clk) begin
    if (busy) busy_n++;
    if (busy4) busy4_n++;
    if (done) done_n++;
    if (done4) done4_n++;
    if (ld_err) err_n++;
    if (ld_err4) err4_n++;
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL read: z_out %h with no expected value queued", z_out);
      end else begin
        rd_t x;
        x = exp_q.pop_front();
        n_vec++;
        if (z_out !== x.e || z_out4 !== x.e) begin
          n_miss++;
          $display("FAIL read Z[%0d][%0d]: got %h (M=2) %h (M=4), want %h", x.r, x.c, z_out, z_out4, x.e);
        end
      end
    end
  end

  task automatic chk(input string nm, input longint a, input longint e);
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic ld(input logic s, input int r, input int c, input int v);
    @(negedge clk);
    ld_valid = 1'b1; ld_sel = s; ld_i = IW'(r); ld_j = IW'(c); ld_data = 16'(v);
    @(posedge clk);
    #1 ld_valid = 1'b0;
  endtask

  task automatic rd(input int r, input int c, input logic [AW-1:0] e);
    rd_t x;
    @(negedge clk);
    z_i = IW'(r); z_j = IW'(c); rd_req = 1'b1;
    x.r = r; x.c = c; x.e = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1 rd_req = 1'b0;
  endtask

  // kinds: 0 identity, 1 zero, 2 all -1, 3 all -32768, 4 4r+c+1, 5 all 2
  function automatic int val(input int kind, input int r, input int c);
    case (kind)
      0: return (r == c) ? 1 : 0;
      1: return 0;
      2: return -1;
      3: return -32768;
      4: return 4 * r + c + 1;
      default: return 2;
    endcase
  endfunction

  task automatic load_all(input int ak, input int bk);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (ak >= 0) ld(1'b0, r, c, val(ak, r, c));
        if (bk >= 0) ld(1'b1, r, c, val(bk, r, c));
      end
  endtask

  task automatic run(input logic am, input bit proto, input bit ldst);
    busy_n = 0; busy4_n = 0; done_n = 0; done4_n = 0; err_n = 0; err4_n = 0;
    @(negedge clk);
    start = 1'b1; acc_mode = am;
    if (ldst) begin
      ld_valid = 1'b1; ld_sel = 1'b0; ld_i = '0; ld_j = '0; ld_data = 16'd2;
    end
    @(posedge clk);
    #1 start = 1'b0; ld_valid = 1'b0;
    for (int t = 0; t < 200 && done_n == 0; t++) begin
      @(negedge clk);
      start = proto && t == 6;
      ld_valid = proto && t == 4;
      if (ld_valid) begin
        ld_sel = 1'b0; ld_i = '0; ld_j = '0; ld_data = 16'd99;
      end
    end
    start = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("busy cycles M=2", busy_n, 32);
    chk("busy cycles M=4", busy4_n, 16);
    chk("done pulses M=2", done_n, 1);
    chk("done pulses M=4", done4_n, 1);
    chk("ld_err pulses M=2", err_n, proto ? 1 : 0);
    chk("ld_err pulses M=4", err4_n, proto ? 1 : 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ld_err", ld_err, 0);
    chk("reset z_out", 64'(z_out), 0);
    rst = 1'b1;
    rd(2, 3, '0);
    // identity
    load_all(0, 4);
    run(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) rd(r, c, AW'(4 * r + c + 1));
    // accumulate, then accumulate with A = 0
    run(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) rd(r, c, AW'(2 * (4 * r + c + 1)));
    load_all(1, -1);
    run(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) rd(c, 3 - c, AW'(2 * (4 * c + (3 - c) + 1)));
    // signed and extremes
    load_all(2, 5);
    run(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) rd(r, r, 34'h3_FFFF_FFF8);
    rd(0, 3, 34'h3_FFFF_FFF8);
    load_all(3, 3);
    run(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) rd(r, 3 - r, 34'h1_0000_0000);
    // protocol: mid-compute load and start are dropped
    load_all(0, 4);
    run(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) rd(0, c, AW'(c + 1));
    rd(3, 2, AW'(15));
    // load together with start: A[0][0] = 2 is used
    run(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) rd(0, c, AW'(2 * (c + 1)));
    rd(1, 1, AW'(6));
    // asynchronous reset in the middle of compute cycle 10
    @(negedge clk);
    start = 1'b1; acc_mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy before reset", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("reset busy M=2", busy, 0);
    chk("reset busy M=4", busy4, 0);
    chk("reset done", done, 0);
    chk("reset z_out M=2", 64'(z_out), 0);
    chk("reset z_out M=4", 64'(z_out4), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < 4; r++) rd(r, (r + 1) % 4, '0);
    load_all(0, 4);
    run(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) rd(r, c, AW'(4 * r + c + 1));
    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
